// File: rtl/gpu_bus_responder_if.sv
// CPU register-port bus plus command FIFO and framebuffer read port of the text GPU.
`timescale 1ns/1ps
interface gpu_bus_responder_if;
    logic       CLK_CPU;
    logic       CE;
    logic       RW;
    logic [1:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic       busy;
    logic       fb_rd_req;
    logic [6:0] fb_rd_x;
    logic [5:0] fb_rd_y;
    logic       fb_rd_ack;
    logic [6:0] fb_rd_data;

    // Responder side
    modport slave (
        input  CLK_CPU, CE, RW, ADDR, DATA_IN, cmd_ready, cur_x, cur_y, busy,
               fb_rd_ack, fb_rd_data,
        output DATA_OUT, DATA_OE, cmd_valid, cmd_data, fb_rd_req, fb_rd_x, fb_rd_y
    );

    // CPU / engine / framebuffer side
    modport master (
        output CLK_CPU, CE, RW, ADDR, DATA_IN, cmd_ready, cur_x, cur_y, busy,
               fb_rd_ack, fb_rd_data,
        input  DATA_OUT, DATA_OE, cmd_valid, cmd_data, fb_rd_req, fb_rd_x, fb_rd_y
    );
endinterface

// File: rtl/gpu_bus_responder.sv
// 6502-side register port of the text GPU: bus sampling, command FIFO, prefetching char reader.
`timescale 1ns/1ps
module gpu_bus_responder #(
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 60,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK_SYS,
    input  logic                RST,
    gpu_bus_responder_if.slave  bus
);
    localparam int unsigned XW = 7;
    localparam int unsigned YW = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SS = SYNC_STAGES;
    localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_REQ} fetch_st_e;

    logic [SS-1:0] phi2_sq, phi2_sd, ce_sq, ce_sd, rw_sq, rw_sd;
    logic          phi2_prev_q, phi2_prev_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          acc_q, acc_d, rwl_q, rwl_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [DW-1:0] cmd_data_q, cmd_data_d;
    logic          ovf_q, ovf_d;
    logic [XW-1:0] rx_q, rx_d, fbx_q, fbx_d;
    logic [YW-1:0] ry_q, ry_d, fby_q, fby_d;
    fetch_st_e     st_q, st_d;
    logic          pend_q, pend_d, req_q, req_d, rdvalid_q, rdvalid_d;
    logic [6:0]    rdchar_q, rdchar_d;

    logic phi2s, ces, rws, rise, fall, commit, wr_cmt, rd_cmt;
    logic push, pop, push_ok, full, empty, ptr_chg, enter_req;
    logic [DW-1:0] status;

    assign phi2s  = phi2_sq[SS-1];
    assign ces    = ce_sq[SS-1];
    assign rws    = rw_sq[SS-1];
    assign rise   = phi2s & ~phi2_prev_q;
    assign fall   = ~phi2s & phi2_prev_q;
    assign commit = fall & acc_q;
    assign wr_cmt = commit & ~rwl_q;
    assign rd_cmt = commit & rwl_q;
    assign full   = (cnt_q == CNT_FULL);
    assign empty  = (cnt_q == '0);
    assign push   = wr_cmt & (addr_q == 2'd0);
    assign pop    = cmd_valid_q & bus.cmd_ready;
    // A pop in the same cycle frees the slot a push at full needs
    assign push_ok = push & (~full | pop);
    assign status  = {ovf_q, full, empty, bus.busy, rdvalid_q, 3'b000};

    assign bus.DATA_OUT  = data_out_q;
    assign bus.DATA_OE   = data_oe_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.fb_rd_req = req_q;
    assign bus.fb_rd_x   = fbx_q;
    assign bus.fb_rd_y   = fby_q;

    // Next-state: bus sampling, register reads, FIFO, read pointer and fetch FSM
    always_comb begin
        phi2_sd     = {phi2_sq[SS-2:0], bus.CLK_CPU};
        ce_sd       = {ce_sq[SS-2:0], bus.CE};
        rw_sd       = {rw_sq[SS-2:0], bus.RW};
        phi2_prev_d = phi2s;
        addr_d      = addr_q;
        din_d       = din_q;
        acc_d       = acc_q;
        rwl_d       = rwl_q;
        data_out_d  = data_out_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        ovf_d       = ovf_q;
        st_d        = st_q;
        req_d       = req_q;
        fbx_d       = fbx_q;
        fby_d       = fby_q;
        rdchar_d    = rdchar_q;
        rdvalid_d   = rdvalid_q;
        enter_req   = 1'b0;

        // DATA_OE tracks the synchronised bus state with no extra lag
        data_oe_d = phi2_sq[SS-2] & ~ce_sq[SS-2] & rw_sq[SS-2];

        if (phi2s) begin
            addr_d = bus.ADDR;
            din_d  = bus.DATA_IN;
            acc_d  = ~ces;
            rwl_d  = rws;
        end

        if (rise && !ces && rws) begin
            case (bus.ADDR)
                2'd0:    data_out_d = status;
                2'd1:    data_out_d = {1'b0, bus.cur_x};
                2'd2:    data_out_d = {2'b00, bus.cur_y};
                default: data_out_d = {rdvalid_q, rdchar_q};
            endcase
        end

        rptr_d      = pop ? rptr_q + AW'(1) : rptr_q;
        wptr_d      = push_ok ? wptr_q + AW'(1) : wptr_q;
        cnt_d       = cnt_q + CW'(push_ok) - CW'(pop);
        cmd_valid_d = (cnt_d != '0);
        // Head bypass when the pushed byte lands in an otherwise empty FIFO
        cmd_data_d  = (push_ok && (cnt_q - CW'(pop)) == '0) ? din_q : mem_q[rptr_d];

        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (rd_cmt && addr_q == 2'd0) begin
            ovf_d = 1'b0;
        end

        if (wr_cmt && addr_q == 2'd1) begin
            rx_d = (din_q[XW-1:0] > X_MAX) ? X_MAX : din_q[XW-1:0];
        end else if (wr_cmt && addr_q == 2'd2) begin
            ry_d = (din_q[YW-1:0] > Y_MAX) ? Y_MAX : din_q[YW-1:0];
        end else if (rd_cmt && addr_q == 2'd3) begin
            if (rx_q == X_MAX) begin
                rx_d = '0;
                ry_d = (ry_q == Y_MAX) ? '0 : ry_q + YW'(1);
            end else begin
                rx_d = rx_q + XW'(1);
            end
        end
        ptr_chg = (rx_d != rx_q) || (ry_d != ry_q);

        case (st_q)
            ST_IDLE: begin
                if (pend_q) enter_req = 1'b1;
            end
            default: begin
                if (bus.fb_rd_ack) begin
                    if (pend_q) begin
                        enter_req = 1'b1;
                    end else begin
                        st_d  = ST_IDLE;
                        req_d = 1'b0;
                        // A pointer move in the ack cycle makes the data stale
                        if (!ptr_chg) begin
                            rdchar_d  = bus.fb_rd_data;
                            rdvalid_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        if (enter_req) begin
            st_d  = ST_REQ;
            req_d = 1'b1;
            fbx_d = rx_q;
            fby_d = ry_q;
        end
        pend_d = ptr_chg | (pend_q & ~enter_req);
        if (ptr_chg) rdvalid_d = 1'b0;
    end

    // State registers; reset arms a fetch of (0,0)
    always_ff @(posedge CLK_SYS or negedge RST) begin
        if (!RST) begin
            phi2_sq     <= '0;
            ce_sq       <= '1;
            rw_sq       <= '0;
            phi2_prev_q <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            acc_q       <= 1'b0;
            rwl_q       <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            ovf_q       <= 1'b0;
            rx_q        <= '0;
            ry_q        <= '0;
            st_q        <= ST_IDLE;
            pend_q      <= 1'b1;
            req_q       <= 1'b0;
            fbx_q       <= '0;
            fby_q       <= '0;
            rdchar_q    <= '0;
            rdvalid_q   <= 1'b0;
        end else begin
            phi2_sq     <= phi2_sd;
            ce_sq       <= ce_sd;
            rw_sq       <= rw_sd;
            phi2_prev_q <= phi2_prev_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            acc_q       <= acc_d;
            rwl_q       <= rwl_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            ovf_q       <= ovf_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            st_q        <= st_d;
            pend_q      <= pend_d;
            req_q       <= req_d;
            fbx_q       <= fbx_d;
            fby_q       <= fby_d;
            rdchar_q    <= rdchar_d;
            rdvalid_q   <= rdvalid_d;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge CLK_SYS) begin
        if (push_ok) mem_q[wptr_q] <= din_q;
    end
endmodule

// File: tb/tb_gpu_bus_responder.sv
// Self-checking bench for gpu_bus_responder: directed cases plus randomised CPU traffic.
`timescale 1ns/1ps
module tb_gpu_bus_responder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    gpu_bus_responder_if bus();

    gpu_bus_responder #(.COLS(80), .ROWS(60), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .CLK_SYS (clk),
        .RST     (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: FIFO contents, overflow flag, read pointer
    logic [7:0] q[$];
    logic [7:0] popped[$];
    logic       ovf_m = 1'b0;
    int         rx_m = 0;
    int         ry_m = 0;

    logic blackout = 1'b1;
    logic pop_ok = 1'b0;
    int   rdy_mode = 0;
    logic rdy_force = 1'b0;
    logic resp_auto = 1'b1;
    int   resp_delay = 3;
    int   man_cnt = 0;
    logic [6:0] man_data = 7'h00;
    logic cyc_ce = 1'b1;
    logic cyc_rw = 1'b1;

    function automatic logic [6:0] fb_char(input int x, input int y);
        return 7'((32'h41 + x + 2 * y) & 32'h7F);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!bus.fb_rd_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, bus.fb_rd_req, 1);
    endtask

    // One 1 MHz CPU cycle; the model applies the commit once the DUT has surely done so
    task automatic cpu_cycle(input logic ce_n, input logic rw, input logic [1:0] a,
                             input logic [7:0] d, input logic do_chk, output logic [7:0] rdat);
        logic [7:0] expv;
        bus.CE = ce_n; bus.RW = rw; bus.ADDR = a; bus.DATA_IN = d;
        cyc_ce = ce_n; cyc_rw = rw;
        #300;
        case (a)
            2'd0:    expv = {ovf_m, q.size() == DEPTH, q.size() == 0, bus.busy, 1'b1, 3'b000};
            2'd1:    expv = {1'b0, bus.cur_x};
            2'd2:    expv = {2'b00, bus.cur_y};
            default: expv = {1'b1, fb_char(rx_m, ry_m)};
        endcase
        bus.CLK_CPU = 1'b1;
        #200; pop_ok = (rdy_mode == 1);
        #280; pop_ok = 1'b0;
        #20;
        rdat = bus.DATA_OUT;
        if (!ce_n && rw) begin
            chk("data_oe_read", bus.DATA_OE, 1);
            if (do_chk) chk($sformatf("read_reg%0d", a), rdat, expv);
        end
        bus.CLK_CPU = 1'b0;
        blackout = 1'b1;
        #200;
        if (!ce_n) begin
            if (!rw) begin
                case (a)
                    2'd0: if (q.size() < DEPTH) q.push_back(d); else ovf_m = 1'b1;
                    2'd1: rx_m = (int'(d[6:0]) > 79) ? 79 : int'(d[6:0]);
                    2'd2: ry_m = (int'(d[5:0]) > 59) ? 59 : int'(d[5:0]);
                    default: ;
                endcase
            end else if (a == 2'd0) begin
                ovf_m = 1'b0;
            end else if (a == 2'd3) begin
                if (rx_m == 79) begin
                    rx_m = 0;
                    ry_m = (ry_m == 59) ? 0 : ry_m + 1;
                end else begin
                    rx_m = rx_m + 1;
                end
            end
        end
        blackout = 1'b0;
        #($urandom_range(0, 15));
    endtask

    // Engine-side ready
    initial begin
        bus.cmd_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rdy_mode == 1) bus.cmd_ready = pop_ok ? 1'($urandom_range(0, 1)) : 1'b0;
            else               bus.cmd_ready = rdy_force;
        end
    end

    // Framebuffer responder: auto mode answers with fb_char(x,y), manual mode pulses man_data
    initial begin
        int cnt = 0;
        int man_done = 0;
        bus.fb_rd_ack = 1'b0;
        bus.fb_rd_data = 7'h00;
        forever begin
            @(posedge clk); #2;
            bus.fb_rd_ack = 1'b0;
            if (man_cnt != man_done) begin
                man_done++;
                bus.fb_rd_ack = 1'b1;
                bus.fb_rd_data = man_data;
                cnt = 0;
            end else if (resp_auto && rst_n) begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.fb_rd_ack = 1'b1;
                        bus.fb_rd_data = fb_char(int'(bus.fb_rd_x), int'(bus.fb_rd_y));
                    end
                end else if (bus.fb_rd_req) begin
                    cnt = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 4));
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle compare: FIFO head, DATA_OE legality, request stability
    initial begin
        logic prev_req = 1'b0;
        logic prev_ack = 1'b0;
        logic [6:0] prev_x = '0;
        logic [5:0] prev_y = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.DATA_OE) chk("data_oe_legal", {cyc_ce, cyc_rw}, 2'b01);
                if (!blackout) begin
                    chk("cmd_valid", bus.cmd_valid, q.size() > 0);
                    if (q.size() > 0) chk("cmd_data", bus.cmd_data, q[0]);
                end
                if (bus.fb_rd_req) begin
                    chk("fb_xy_range", (bus.fb_rd_x < 80) && (bus.fb_rd_y < 60), 1);
                    if (prev_req && !prev_ack) chk("fb_xy_stable", {bus.fb_rd_x, bus.fb_rd_y}, {prev_x, prev_y});
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    popped.push_back(bus.cmd_data);
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
            prev_req = bus.fb_rd_req & rst_n;
            prev_ack = bus.fb_rd_ack;
            prev_x = bus.fb_rd_x;
            prev_y = bus.fb_rd_y;
        end
    end

    // Watchdog
    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] rd;
        bus.CLK_CPU = 1'b0; bus.CE = 1'b1; bus.RW = 1'b1; bus.ADDR = 2'd0; bus.DATA_IN = 8'h00;
        bus.busy = 1'b0; bus.cur_x = 7'd0; bus.cur_y = 6'd0;
        #1;
        chk("rst_data_out", bus.DATA_OUT, 0);
        chk("rst_data_oe", bus.DATA_OE, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_fb_req", bus.fb_rd_req, 0);
        #($urandom_range(40, 59));
        rst_n = 1'b1;
        blackout = 1'b0;

        // Initial (0,0) fetch answered 3 cycles later with 0x41
        wait_req("t1_req");
        chk("t1_fb_xy", {bus.fb_rd_x, bus.fb_rd_y}, 13'h0);
        repeat (10) @(negedge clk);
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b1, rd);
        chk("t1_reg3", rd, 8'hC1);
        cpu_cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, rd);
        chk("t1_status", rd, 8'h28);
        resp_delay = 0;

        // Two commands held, then popped in two ready cycles
        cpu_cycle(1'b0, 1'b0, 2'd0, 8'h48, 1'b1, rd);
        cpu_cycle(1'b0, 1'b0, 2'd0, 8'h49, 1'b1, rd);
        @(negedge clk);
        chk("t2_valid", bus.cmd_valid, 1);
        chk("t2_head", bus.cmd_data, 8'h48);
        popped.delete();
        @(posedge clk); #1 rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1 rdy_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_pop_count", popped.size(), 2);
        chk("t2_pops", {popped[0], popped[1]}, 16'h4849);
        chk("t2_empty", bus.cmd_valid, 0);
        cpu_cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, rd);
        chk("t2_status", rd, 8'h28);

        // Overflow on the 9th push, cleared by the status read
        for (int i = 0; i < 9; i++) cpu_cycle(1'b0, 1'b0, 2'd0, 8'(8'h10 + i), 1'b1, rd);
        cpu_cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, rd);
        chk("t3_status_ovf", rd, 8'hC8);
        cpu_cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, rd);
        chk("t3_status_clr", rd, 8'h48);
        popped.delete();
        @(posedge clk); #1 rdy_force = 1'b1;
        repeat (12) @(posedge clk);
        #1 rdy_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_drain_count", popped.size(), 8);
        chk("t3_drain_ends", {popped[0], popped[7]}, 16'h1017);

        // Pointer at the last cell, then wrap to (0,0)
        cpu_cycle(1'b0, 1'b0, 2'd1, 8'd79, 1'b1, rd);
        cpu_cycle(1'b0, 1'b0, 2'd2, 8'd59, 1'b1, rd);
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b1, rd);
        chk("t4_reg3_last", rd, 8'h86);
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b1, rd);
        chk("t4_reg3_wrap", rd, 8'hC1);

        // Clamp, then pointer move during an outstanding request
        repeat (20) @(negedge clk);
        resp_auto = 1'b0;
        cpu_cycle(1'b0, 1'b0, 2'd1, 8'd100, 1'b1, rd);
        wait_req("t5_req");
        chk("t5_clamp_x", bus.fb_rd_x, 79);
        cpu_cycle(1'b0, 1'b0, 2'd1, 8'd5, 1'b1, rd);
        chk("t5_still_req", bus.fb_rd_req, 1);
        man_data = 7'h7F; man_cnt++;
        repeat (4) @(negedge clk);
        chk("t5_rereq", bus.fb_rd_req, 1);
        chk("t5_rereq_xy", {bus.fb_rd_x, bus.fb_rd_y}, {7'd5, 6'd0});
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b0, rd);
        chk("t5_stale", rd, 8'h42);
        man_data = 7'h11; man_cnt++;
        repeat (4) @(negedge clk);
        chk("t5_rereq6", {bus.fb_rd_req, bus.fb_rd_x}, {1'b1, 7'd6});
        resp_auto = 1'b1;
        repeat (10) @(negedge clk);
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b1, rd);
        chk("t5_reg3", rd, {1'b1, fb_char(6, 0)});

        // Reset in the middle of a fetch; an ack during reset is ignored
        resp_auto = 1'b0;
        cpu_cycle(1'b0, 1'b0, 2'd0, 8'h55, 1'b1, rd);
        cpu_cycle(1'b0, 1'b0, 2'd1, 8'd20, 1'b1, rd);
        wait_req("tr_req");
        @(negedge clk); #3;
        rst_n = 1'b0;
        blackout = 1'b1;
        q.delete(); ovf_m = 1'b0; rx_m = 0; ry_m = 0;
        #1;
        chk("tr_req_abort", bus.fb_rd_req, 0);
        chk("tr_outputs", {bus.cmd_valid, bus.DATA_OE, bus.DATA_OUT}, 10'h0);
        man_data = 7'h33; man_cnt++;
        repeat (4) @(negedge clk);
        chk("tr_req_in_reset", bus.fb_rd_req, 0);
        rst_n = 1'b1;
        blackout = 1'b0;
        wait_req("tr_refetch");
        chk("tr_refetch_xy", {bus.fb_rd_x, bus.fb_rd_y}, 13'h0);
        resp_auto = 1'b1;
        repeat (10) @(negedge clk);
        cpu_cycle(1'b0, 1'b1, 2'd3, 8'h00, 1'b1, rd);
        chk("tr_reg3", rd, 8'hC1);

        // Randomised traffic: random phase, mixed registers, ready bursts and FIFO back-pressure
        for (int i = 0; i < 160; i++) begin
            if (i == 60)  begin rdy_mode = 0; rdy_force = 1'b0; end
            if (i == 110) rdy_mode = 1;
            if (i < 60) rdy_mode = 1;
            bus.busy  = 1'($urandom_range(0, 1));
            bus.cur_x = 7'($urandom_range(0, 127));
            bus.cur_y = 6'($urandom_range(0, 63));
            cpu_cycle(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, rd);
        end
        rdy_mode = 0; rdy_force = 1'b1;
        repeat (12) @(negedge clk);
        chk("final_empty", bus.cmd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
